// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Single-outstanding instruction fetch unit with redirect and
//               stale-response discard. Optional macro IFU_MISALIGN_CHK_EN
//               turns misaligned redirect targets into fetch faults.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        fetch_err
);

    localparam logic [1:0] c_ST_REQ  = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_OUT  = 2'd2;

    logic [1:0]  r_state,   w_state_nxt;
    logic [31:0] r_pc,      w_pc_nxt;
    logic [31:0] r_tgt,     w_tgt_nxt;
    logic [31:0] r_inst,    w_inst_nxt;
    logic [31:0] r_inst_pc, w_inst_pc_nxt;
    logic        r_err,     w_err_nxt;
    logic        r_pend,    w_pend_nxt;
    logic        r_discard, w_discard_nxt;

    logic [31:0] w_redir_tgt;
    logic        w_goto;
    logic [31:0] w_goto_pc;
    logic        w_goto_mis;

`ifdef IFU_MISALIGN_CHK_EN
    assign w_redir_tgt = redirect_pc;
    assign w_goto_mis  = (w_goto_pc[1:0] != 2'b00);
`else
    assign w_redir_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign w_goto_mis  = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_tgt_nxt     = r_tgt;
        w_inst_nxt    = r_inst;
        w_inst_pc_nxt = r_inst_pc;
        w_err_nxt     = r_err;
        w_pend_nxt    = r_pend;
        w_discard_nxt = r_discard;
        w_goto        = 1'b0;
        w_goto_pc     = r_tgt;

        case (r_state)
            c_ST_REQ: begin
                if (imem_req_ready) begin
                    // A redirect seen before or at acceptance poisons this response
                    w_state_nxt = c_ST_WAIT;
                    w_pend_nxt  = 1'b0;
                    if (redirect_valid) begin
                        w_discard_nxt = 1'b1;
                        w_tgt_nxt     = w_redir_tgt;
                    end else if (r_pend) begin
                        w_discard_nxt = 1'b1;
                    end
                end else if (redirect_valid) begin
                    w_pend_nxt = 1'b1;
                    w_tgt_nxt  = w_redir_tgt;
                end
            end
            c_ST_WAIT: begin
                if (redirect_valid) begin
                    w_discard_nxt = 1'b1;
                    w_tgt_nxt     = w_redir_tgt;
                end
                if (imem_rsp_valid) begin
                    if (redirect_valid || r_discard) begin
                        w_discard_nxt = 1'b0;
                        w_goto        = 1'b1;
                        w_goto_pc     = redirect_valid ? w_redir_tgt : r_tgt;
                    end else begin
                        w_state_nxt   = c_ST_OUT;
                        w_inst_nxt    = imem_rsp_err ? 32'h0000_0000 : imem_rsp_data;
                        w_err_nxt     = imem_rsp_err;
                        w_inst_pc_nxt = r_pc;
                    end
                end
            end
            c_ST_OUT: begin
                if (redirect_valid) begin
                    w_goto    = 1'b1;
                    w_goto_pc = w_redir_tgt;
                end else if (inst_ready) begin
                    w_state_nxt = c_ST_REQ;
                    w_pc_nxt    = r_pc + 32'd4;
                end
            end
            default: begin
                w_state_nxt = c_ST_REQ;
            end
        endcase

        // Misaligned targets skip memory and present a fault directly
        if (w_goto) begin
            if (w_goto_mis) begin
                w_state_nxt   = c_ST_OUT;
                w_inst_nxt    = 32'h0000_0000;
                w_err_nxt     = 1'b1;
                w_inst_pc_nxt = w_goto_pc;
                w_pc_nxt      = w_goto_pc & 32'hFFFF_FFFC;
            end else begin
                w_state_nxt = c_ST_REQ;
                w_pc_nxt    = w_goto_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_REQ;
            r_pc      <= RESET_PC;
            r_tgt     <= RESET_PC;
            r_inst    <= 32'h0000_0000;
            r_inst_pc <= 32'h0000_0000;
            r_err     <= 1'b0;
            r_pend    <= 1'b0;
            r_discard <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_tgt     <= w_tgt_nxt;
            r_inst    <= w_inst_nxt;
            r_inst_pc <= w_inst_pc_nxt;
            r_err     <= w_err_nxt;
            r_pend    <= w_pend_nxt;
            r_discard <= w_discard_nxt;
        end
    end

    assign imem_req_valid = (r_state == c_ST_REQ) && !rst;
    assign imem_req_addr  = r_pc;
    assign inst_valid     = (r_state == c_ST_OUT);
    assign inst_out       = r_inst;
    assign inst_pc        = r_inst_pc;
    assign fetch_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch
// Description : Self-checking bench for inst_fetch; delivered instructions are
//               checked against a scoreboard queue filled as responses are driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        fetch_err;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic r_seen   = 1'b0;

    inst_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    // Each newly presented instruction must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            r_seen <= 1'b0;
        end else if (inst_valid) begin
            if (!r_seen) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_inst: got out=%h pc=%h err=%b, required no instruction",
                             inst_out, inst_pc, fetch_err);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if ({inst_out, inst_pc, fetch_err} !== {e.data, e.pc, e.err}) begin
                        failures++;
                        $display("FAIL sb_inst: got out=%h pc=%h err=%b, required out=%h pc=%h err=%b",
                                 inst_out, inst_pc, fetch_err, e.data, e.pc, e.err);
                    end
                end
            end
            r_seen <= !(inst_ready || redirect_valid);
        end else begin
            r_seen <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starting at a negedge with the DUT in REQ: accept, then respond next cycle
    task automatic accept_and_respond(input logic [31:0] data, input logic err,
                                      input logic [31:0] pc, input logic push);
        tick();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        imem_rsp_err   = err;
        if (push) exp_q.push_back({(err ? 32'h0 : data), pc, err});
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        @(negedge clk);
    endtask

    task automatic handshake();
        tick();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({imem_req_valid, inst_valid, inst_out, inst_pc, fetch_err} !== 67'd0) begin
            failures++;
            $display("FAIL reset_outputs: got rv=%b iv=%b out=%h pc=%h err=%b, required all zero",
                     imem_req_valid, inst_valid, inst_out, inst_pc, fetch_err);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
            failures++;
            $display("FAIL reset_first_req: got rv=%b addr=%h, required rv=1 addr=80000000",
                     imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_basic();
        accept_and_respond(32'h0010_0093, 1'b0, 32'h8000_0000, 1'b1);
        checks++;
        if (inst_valid !== 1'b1 || inst_out !== 32'h0010_0093 || imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_out: got iv=%b out=%h rv=%b, required iv=1 out=00100093 rv=0",
                     inst_valid, inst_out, imem_req_valid);
        end
        handshake();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_next: got rv=%b addr=%h iv=%b, required rv=1 addr=80000004 iv=0",
                     imem_req_valid, imem_req_addr, inst_valid);
        end
    endtask

    task automatic test_stall();
        accept_and_respond(32'h0020_8113, 1'b0, 32'h8000_0004, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if (inst_valid !== 1'b1 || inst_out !== 32'h0020_8113 ||
                inst_pc !== 32'h8000_0004 || imem_req_valid !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got iv=%b out=%h pc=%h rv=%b, required iv=1 out=00208113 pc=80000004 rv=0",
                         i, inst_valid, inst_out, inst_pc, imem_req_valid);
            end
        end
        handshake();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0008) begin
            failures++;
            $display("FAIL stall_next: got rv=%b addr=%h, required rv=1 addr=80000008",
                     imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_redirect_wait();
        // Redirect while waiting: stale word dropped, refetch at target
        tick();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0001;
        tick();
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin
            failures++;
            $display("FAIL redir_wait: got iv=%b rv=%b addr=%h, required iv=0 rv=1 addr=80000100",
                     inst_valid, imem_req_valid, imem_req_addr);
        end
        // A second redirect on the response cycle overrides the first
        tick();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0400;
        tick();
        redirect_pc    = 32'h8000_0500;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0002;
        tick();
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0 || imem_req_addr !== 32'h8000_0500) begin
            failures++;
            $display("FAIL redir_newest: got iv=%b addr=%h, required iv=0 addr=80000500",
                     inst_valid, imem_req_addr);
        end
        // Redirect before acceptance: request stays stable, response dropped
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0500) begin
            failures++;
            $display("FAIL redir_pend_hold: got rv=%b addr=%h, required rv=1 addr=80000500",
                     imem_req_valid, imem_req_addr);
        end
        accept_and_respond(32'hBAD0_0003, 1'b0, 32'h8000_0500, 1'b0);
        checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0300) begin
            failures++;
            $display("FAIL redir_pend: got iv=%b rv=%b addr=%h, required iv=0 rv=1 addr=80000300",
                     inst_valid, imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_redirect_handshake();
        accept_and_respond(32'h00A0_0113, 1'b0, 32'h8000_0300, 1'b1);
        tick();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        tick();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) begin
            failures++;
            $display("FAIL redir_hs: got iv=%b rv=%b addr=%h, required iv=0 rv=1 addr=80000200",
                     inst_valid, imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_rsp_err();
        accept_and_respond(32'hDEAD_BEEF, 1'b1, 32'h8000_0200, 1'b1);
        checks++;
        if (fetch_err !== 1'b1 || inst_out !== 32'h0 || inst_pc !== 32'h8000_0200) begin
            failures++;
            $display("FAIL rsp_err: got err=%b out=%h pc=%h, required err=1 out=00000000 pc=80000200",
                     fetch_err, inst_out, inst_pc);
        end
        handshake();
        checks++;
        if (imem_req_addr !== 32'h8000_0204 || imem_req_valid !== 1'b1) begin
            failures++;
            $display("FAIL rsp_err_next: got rv=%b addr=%h, required rv=1 addr=80000204",
                     imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_misalign();
        accept_and_respond(32'h0000_0013, 1'b0, 32'h8000_0204, 1'b1);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
`ifdef IFU_MISALIGN_CHK_EN
        exp_q.push_back({32'h0, 32'h8000_0102, 1'b1});
`endif
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
`ifdef IFU_MISALIGN_CHK_EN
        if (inst_valid !== 1'b1 || fetch_err !== 1'b1 || inst_pc !== 32'h8000_0102 ||
            inst_out !== 32'h0 || imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL misalign_fault: got iv=%b err=%b pc=%h out=%h rv=%b, required iv=1 err=1 pc=80000102 out=0 rv=0",
                     inst_valid, fetch_err, inst_pc, inst_out, imem_req_valid);
        end
        handshake();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0104) begin
            failures++;
            $display("FAIL misalign_next: got rv=%b addr=%h, required rv=1 addr=80000104",
                     imem_req_valid, imem_req_addr);
        end
`else
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin
            failures++;
            $display("FAIL misalign_clear: got iv=%b rv=%b addr=%h, required iv=0 rv=1 addr=80000100",
                     inst_valid, imem_req_valid, imem_req_addr);
        end
`endif
    endtask

    task automatic test_reset_mid();
        tick();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst            = 1'b1;
        tick();
        rst            = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0004;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000 || inst_valid !== 1'b0 ||
            inst_out !== 32'h0 || inst_pc !== 32'h0 || fetch_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got rv=%b addr=%h iv=%b out=%h pc=%h err=%b, required rv=1 addr=80000000 rest zero",
                     imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc, fetch_err);
        end
        tick();
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
            failures++;
            $display("FAIL reset_late_rsp: got iv=%b rv=%b addr=%h, required iv=0 rv=1 addr=80000000",
                     inst_valid, imem_req_valid, imem_req_addr);
        end
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;

        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_handshake();
        test_rsp_err();
        test_misalign();
        test_reset_mid();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d undelivered instructions, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 imem_req_valid  output  1  fetch request valid.
REQ-005 imem_req_ready  input  1  memory accepts request.
REQ-006 imem_req_addr  output  32  fetch address, word-aligned.
REQ-007 imem_rsp_valid  input  1  response valid; memory always accepts responses, one per accepted request.
REQ-008 imem_rsp_data  input  32  fetched instruction word.
REQ-009 imem_rsp_err  input  1  bus error for this response.
REQ-010 redirect_valid  input  1  control-flow redirect from execute.
REQ-011 redirect_pc  input  32  redirect target.
REQ-012 inst_valid  output  1  instruction available to decode/ImmGen.
REQ-013 inst_ready  input  1  decode accepts instruction.
REQ-014 inst_out  output  32  instruction word; bits [31:7] drive the immediate generator.
REQ-015 inst_pc  output  32  PC of inst_out.
REQ-016 fetch_err  output  1  instruction carries a fetch fault.

Function
REQ-017 States SHALL be REQ (request asserted), WAIT (awaiting response), OUT (holding instruction).
REQ-018 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready -> WAIT.
REQ-019 imem_req_addr SHALL stay stable while imem_req_valid && !imem_req_ready; the request is never withdrawn.
REQ-020 WAIT: on imem_rsp_valid, capture data/err into registers -> OUT; inst_valid rises the next cycle (one-cycle registered latency).
REQ-021 OUT: inst_valid=1; inst_out/inst_pc/fetch_err stable until inst_valid && inst_ready.
REQ-022 Handshake in OUT: pc <= pc+4 (wrap at 2^32 to 0), -> REQ; imem_req_valid asserted the following cycle.
REQ-023 Redirect in OUT: drop the held instruction (inst_valid=0 next cycle), pc <= redirect_pc, -> REQ; redirect beats a simultaneous handshake.
REQ-024 Redirect in REQ before acceptance: record pending target; current request completes; its response SHALL be discarded; then -> REQ at the target.
REQ-025 Redirect in REQ on the acceptance cycle, or in WAIT: set discard flag; the response SHALL be discarded; -> REQ at target.
REQ-026 Redirect on the cycle the discarded response arrives: the newest target wins.
REQ-027 Discarded responses SHALL never raise inst_valid.
REQ-028 imem_rsp_err=1: fetch_err=1, inst_out=32'h0000_0000, inst_pc=faulting pc; normal handshake applies.
REQ-029 At most one request outstanding; imem_rsp_valid outside WAIT/discard is ignored.

Reset
REQ-030 rst SHALL force state=REQ, pc=RESET_PC, discard/pending cleared, inst_valid=0, inst_out=0, inst_pc=0, fetch_err=0; imem_req_valid=0 during the reset cycle, 1 in the first cycle after.
REQ-031 Reset mid-transaction SHALL abandon any outstanding request; a late response for it is ignored until the first new request is accepted.

Configuration
REQ-032 Macro IFU_MISALIGN_CHK_EN defined: redirect_pc[1:0]!=0 SHALL issue no memory request and go directly to OUT with fetch_err=1, inst_out=0, inst_pc=redirect_pc.
REQ-033 Macro IFU_MISALIGN_CHK_EN undefined: redirect_pc[1:0] SHALL be cleared to 2'b00; no misalignment fault is generated.

Verification
REQ-034 Reset; imem_req_ready=1; rsp 32'h0010_0093 one cycle later -> inst_valid with inst_out=32'h0010_0093, inst_pc=32'h8000_0000; after handshake, next request addr 32'h8000_0004.
REQ-035 inst_ready=0 for 5 cycles -> inst_out/inst_pc unchanged, no new request; ready=1 -> request at pc+4.
REQ-036 Redirect to 32'h8000_0100 in WAIT -> pending response discarded, next request addr 32'h8000_0100, inst_valid never asserted for the stale word.
REQ-037 Redirect 32'h8000_0200 same cycle as handshake in OUT -> next request addr 32'h8000_0200, not pc+4.
REQ-038 imem_rsp_err=1 -> fetch_err=1, inst_out=0; with IFU_MISALIGN_CHK_EN, redirect 32'h8000_0102 -> fetch_err=1 and no imem_req_valid for that pc.
REQ-039 rst asserted in WAIT, late response following -> outputs at reset values, first request addr RESET_PC, late response ignored.
